// File: rtl/tristate_scan_poller_pkg.sv
// Shared definitions for the tri-state scan poller.
// Contents: FSM state encoding, slot count, counter width, and two helper
// functions (slot -> one-hot enable decode, saturating counter increment).
package tristate_scan_poller_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TURN  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_CAPT  = 2'd3
    } state_e;

    // One-hot buffer enable for a slot index.
    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
        logic [NUM_SLOTS-1:0] v;
        v = {{(NUM_SLOTS-1){1'b0}}, 1'b1};
        return v << s;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] v;
        if (c == {CNT_W{1'b1}}) begin
            v = c;
        end else begin
            v = c + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return v;
    endfunction

endpackage

// File: rtl/tristate_scan_poller_sync_edge_det.sv
// sync_edge_det: 2-FF synchronizer for a slow asynchronous level plus a
// one-cycle rising-edge pulse in the destination clock domain.
// Ports:
//   i_clk   in  destination clock
//   i_rst   in  asynchronous active-high reset
//   i_async in  asynchronous input level
//   o_rise  out one-cycle pulse on a synchronized rising edge
// A rising edge is only reported after the synchronized level has been seen
// low since reset, so an input already high at reset release yields no pulse.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic       r_meta;
    logic       r_sync;
    logic       r_hist;
    logic       r_armed;
    logic [1:0] r_fill;

    // Synchronizer chain, edge history and arming after a genuine low level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_hist  <= 1'b0;
            r_armed <= 1'b0;
            r_fill  <= 2'b00;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
            // r_fill[1] marks that r_sync now holds a real sample, not the reset value.
            r_fill <= {r_fill[0], 1'b1};
            if (r_fill[1] && !r_sync) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
        end
    end

    assign o_rise = r_sync & ~r_hist & r_armed;

endmodule

// File: rtl/tristate_scan_poller.sv
// tristate_scan_poller: on each synchronized scan tick, grants one of four
// sources the shared tri-state bus after an all-off turnaround, lets the bus
// settle, captures the resolved value and releases the bus.
// Ports:
//   inclk     in  system clock
//   rst       in  asynchronous active-high reset
//   scan_clk  in  asynchronous scan clock from upstream
//   scan_sel  in  slot index, stable around each synchronized rising edge
//   src_valid in  per-slot source-present flags
//   bus_oe    out registered one-hot buffer enables (zero when idle)
//   bus_rd    in  resolved bus value
//   cap_data  out last captured value
//   cap_slot  out slot of last capture
//   cap_stb   out one-cycle pulse when cap_data/cap_slot update
//   busy      out high outside IDLE
//   skip_cnt  out saturating count of ticks on absent slots
//   ovr_cnt   out saturating count of ticks ignored while busy
module tristate_scan_poller
    import tristate_scan_poller_pkg::*;
#(
    parameter int W      = 8,
    parameter int TURN   = 1,
    parameter int SETTLE = 2
) (
    input  logic                 inclk,
    input  logic                 rst,
    input  logic                 scan_clk,
    input  logic [SLOT_W-1:0]    scan_sel,
    input  logic [NUM_SLOTS-1:0] src_valid,
    output logic [NUM_SLOTS-1:0] bus_oe,
    input  logic [W-1:0]         bus_rd,
    output logic [W-1:0]         cap_data,
    output logic [SLOT_W-1:0]    cap_slot,
    output logic                 cap_stb,
    output logic                 busy,
    output logic [CNT_W-1:0]     skip_cnt,
    output logic [CNT_W-1:0]     ovr_cnt
);

    // Phase counter is wide enough for TURN/SETTLE up to 65536.
    localparam int              CW          = 16;
    localparam logic [CW-1:0]   TURN_LAST   = CW'(TURN - 1);
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);

    state_e                r_state;
    state_e                w_state_next;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_next;
    logic [SLOT_W-1:0]     r_slot;
    logic [SLOT_W-1:0]     w_slot_next;
    logic [NUM_SLOTS-1:0]  r_bus_oe;
    logic [NUM_SLOTS-1:0]  w_oe_next;
    logic                  r_busy;
    logic                  w_tick;
    logic                  w_skip;
    logic                  w_ovr;
    logic [W-1:0]          r_cap_data;
    logic [SLOT_W-1:0]     r_cap_slot;
    logic                  r_cap_stb;
    logic [CNT_W-1:0]      r_skip_cnt;
    logic [CNT_W-1:0]      r_ovr_cnt;

    sync_edge_det u_sync (
        .i_clk   (inclk),
        .i_rst   (rst),
        .i_async (scan_clk),
        .o_rise  (w_tick)
    );

    // Next-state, phase counter and event decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_slot_next  = r_slot;
        w_skip       = 1'b0;
        w_ovr        = 1'b0;
        w_oe_next    = {NUM_SLOTS{1'b0}};
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = {CW{1'b0}};
                if (w_tick) begin
                    if (src_valid[scan_sel]) begin
                        w_state_next = ST_TURN;
                        w_slot_next  = scan_sel;
                    end else begin
                        w_skip = 1'b1;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_TURN: begin
                w_ovr = w_tick;
                if (r_cnt == TURN_LAST) begin
                    w_state_next = ST_DRIVE;
                    w_cnt_next   = {CW{1'b0}};
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            ST_DRIVE: begin
                w_ovr = w_tick;
                if (r_cnt == SETTLE_LAST) begin
                    w_state_next = ST_CAPT;
                    w_cnt_next   = {CW{1'b0}};
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            ST_CAPT: begin
                w_ovr        = w_tick;
                w_state_next = ST_IDLE;
                w_cnt_next   = {CW{1'b0}};
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = {CW{1'b0}};
            end
        endcase
        // Enables are decoded from the next state so the registered bus_oe
        // lines up with the state it belongs to; TURN always precedes DRIVE.
        if ((w_state_next == ST_DRIVE) || (w_state_next == ST_CAPT)) begin
            w_oe_next = slot_onehot(w_slot_next);
        end else begin
            w_oe_next = {NUM_SLOTS{1'b0}};
        end
    end

    // FSM state, phase counter, granted slot, enables and busy flag.
    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_slot   <= {SLOT_W{1'b0}};
            r_bus_oe <= {NUM_SLOTS{1'b0}};
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_slot   <= w_slot_next;
            r_bus_oe <= w_oe_next;
            r_busy   <= (w_state_next != ST_IDLE);
        end
    end

    // Capture of the resolved bus at the end of the CAPT cycle.
    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            r_cap_data <= {W{1'b0}};
            r_cap_slot <= {SLOT_W{1'b0}};
            r_cap_stb  <= 1'b0;
        end else if (r_state == ST_CAPT) begin
            r_cap_data <= bus_rd;
            r_cap_slot <= r_slot;
            r_cap_stb  <= 1'b1;
        end else begin
            r_cap_stb  <= 1'b0;
        end
    end

    // Saturating skip and overrun counters.
    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            r_skip_cnt <= {CNT_W{1'b0}};
            r_ovr_cnt  <= {CNT_W{1'b0}};
        end else begin
            if (w_skip) begin
                r_skip_cnt <= sat_inc(r_skip_cnt);
            end else begin
                r_skip_cnt <= r_skip_cnt;
            end
            if (w_ovr) begin
                r_ovr_cnt <= sat_inc(r_ovr_cnt);
            end else begin
                r_ovr_cnt <= r_ovr_cnt;
            end
        end
    end

    assign bus_oe   = r_bus_oe;
    assign busy     = r_busy;
    assign cap_data = r_cap_data;
    assign cap_slot = r_cap_slot;
    assign cap_stb  = r_cap_stb;
    assign skip_cnt = r_skip_cnt;
    assign ovr_cnt  = r_ovr_cnt;

endmodule

// File: tb/tb_tristate_scan_poller.sv
// Bench for tristate_scan_poller: directed scenarios plus randomized scan
// ticks. The stimulus side predicts each tick's cycle and outcome and queues
// expected grants/captures; a negedge monitor compares DUT outputs against
// them. A second instance with TURN=3, SETTLE=4 is checked for latency.
module tb_tristate_scan_poller;

    localparam int W       = 8;
    localparam int TURN    = 1;
    localparam int SETTLE  = 2;
    localparam int L       = TURN + SETTLE + 2;
    localparam int TURN2   = 3;
    localparam int SETTLE2 = 4;
    localparam int L2      = TURN2 + SETTLE2 + 2;

    logic         inclk = 1'b0;
    logic         rst = 1'b1;
    logic         scan_clk = 1'b0;
    logic [1:0]   scan_sel = 2'd0;
    logic [3:0]   src_valid = 4'd0;
    logic [W-1:0] bus_rd;
    logic [3:0]   bus_oe,   bus_oe2;
    logic [W-1:0] cap_data, cap_data2;
    logic [1:0]   cap_slot, cap_slot2;
    logic         cap_stb,  cap_stb2;
    logic         busy,     busy2;
    logic [7:0]   skip_cnt, skip_cnt2;
    logic [7:0]   ovr_cnt,  ovr_cnt2;

    tristate_scan_poller #(.W(W), .TURN(TURN), .SETTLE(SETTLE)) u_dut (
        .inclk(inclk), .rst(rst), .scan_clk(scan_clk), .scan_sel(scan_sel),
        .src_valid(src_valid), .bus_oe(bus_oe), .bus_rd(bus_rd),
        .cap_data(cap_data), .cap_slot(cap_slot), .cap_stb(cap_stb),
        .busy(busy), .skip_cnt(skip_cnt), .ovr_cnt(ovr_cnt)
    );

    tristate_scan_poller #(.W(W), .TURN(TURN2), .SETTLE(SETTLE2)) u_dut2 (
        .inclk(inclk), .rst(rst), .scan_clk(scan_clk), .scan_sel(scan_sel),
        .src_valid(src_valid), .bus_oe(bus_oe2), .bus_rd(bus_rd),
        .cap_data(cap_data2), .cap_slot(cap_slot2), .cap_stb(cap_stb2),
        .busy(busy2), .skip_cnt(skip_cnt2), .ovr_cnt(ovr_cnt2)
    );

    always #5 inclk = ~inclk;

    int cyc = 0;
    always @(posedge inclk) cyc <= cyc + 1;

    // External sources: each drives its data when enabled; wired-OR resolution.
    logic [W-1:0] src_data [4];
    always_comb begin
        bus_rd = '0;
        for (int i = 0; i < 4; i++) begin
            if (bus_oe[i]) bus_rd = bus_rd | src_data[i];
        end
    end

    typedef struct { int tk; logic [1:0] slot; } acc_t;
    typedef struct { logic [1:0] slot; logic [W-1:0] data; int at; } cap_t;

    acc_t acc_q[$];
    cap_t cap_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 1'b0;
    int   m_last_t = -100;
    int   m_skip = 0;
    int   m_ovr = 0;
    logic [3:0] prev_oe = 4'd0;
    int   d2_oe_cnt = 0;
    int   d2_stb_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One scan_clk pulse: high for hi cycles, then low for lo cycles.
    // The tick appears two cycles after the rise; the reference model decides
    // its fate from the transaction window of the last accepted tick.
    task automatic pulse(input logic [1:0] sel, input logic [3:0] valid,
                         input int hi, input int lo, output int tk);
        @(negedge inclk); #1;
        scan_sel  = sel;
        src_valid = valid;
        scan_clk  = 1'b1;
        tk = cyc + 2;
        if (tk < m_last_t + L) begin
            if (m_ovr < 255) m_ovr++;
        end else if (valid[sel]) begin
            m_last_t = tk;
            acc_q.push_back('{tk: tk, slot: sel});
            cap_q.push_back('{slot: sel, data: src_data[sel], at: tk + L});
        end else begin
            if (m_skip < 255) m_skip++;
        end
        repeat (hi) @(negedge inclk);
        #1 scan_clk = 1'b0;
        repeat (lo - 1) @(negedge inclk);
    endtask

    // Monitor: expected enables/busy from queued grants; captures popped on cap_stb.
    always @(negedge inclk) begin
        logic [3:0] exp_oe;
        logic       exp_busy;
        cap_t       e;
        if (!rst && chk_en) begin
            exp_oe   = 4'd0;
            exp_busy = 1'b0;
            while (acc_q.size() > 0 && acc_q[0].tk + L < cyc) void'(acc_q.pop_front());
            foreach (acc_q[i]) begin
                if (cyc > acc_q[i].tk && cyc < acc_q[i].tk + L) exp_busy = 1'b1;
                if (cyc > acc_q[i].tk + TURN && cyc < acc_q[i].tk + L)
                    exp_oe = 4'b0001 << acc_q[i].slot;
            end
            check("bus_oe", {28'd0, bus_oe}, {28'd0, exp_oe});
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("oe_onehot", {31'd0, ($countones(bus_oe) <= 1)}, 32'd1);
            check("oe_gap", {31'd0, (prev_oe != 4'd0 && bus_oe != 4'd0 && bus_oe != prev_oe)}, 32'd0);
            if (cap_stb) begin
                if (cap_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL cap_stb: got unexpected strobe, expected none (cycle %0d)", cyc);
                end else begin
                    e = cap_q.pop_front();
                    check("cap_cycle", cyc, e.at);
                    check("cap_slot", {30'd0, cap_slot}, {30'd0, e.slot});
                    check("cap_data", {24'd0, cap_data}, {24'd0, e.data});
                end
            end else if (cap_q.size() > 0 && cap_q[0].at < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL cap_stb: got no strobe, expected one at cycle %0d", cap_q[0].at);
                void'(cap_q.pop_front());
            end
            prev_oe = bus_oe;
        end else begin
            prev_oe = 4'd0;
        end
    end

    // Second instance: count enabled cycles and record the first strobe.
    always @(negedge inclk) begin
        if (!rst) begin
            if (bus_oe2 != 4'd0) d2_oe_cnt++;
            if (cap_stb2 && d2_stb_cyc < 0) d2_stb_cyc = cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int tk;
        int t0;
        for (int i = 0; i < 4; i++) src_data[i] = 8'h00;

        // Reset values.
        #1;
        check("rst_bus_oe", {28'd0, bus_oe}, 32'd0);
        check("rst_cap_data", {24'd0, cap_data}, 32'd0);
        check("rst_cap_slot", {30'd0, cap_slot}, 32'd0);
        check("rst_cap_stb", {31'd0, cap_stb}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_skip", {24'd0, skip_cnt}, 32'd0);
        check("rst_ovr", {24'd0, ovr_cnt}, 32'd0);
        repeat (3) @(negedge inclk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(negedge inclk);

        // Single grant of slot 2, also timing the TURN=3/SETTLE=4 instance.
        src_data[2] = 8'hA5;
        d2_oe_cnt  = 0;
        d2_stb_cyc = -1;
        pulse(2'd2, 4'b1111, 3, 3, t0);
        repeat (12) @(negedge inclk);
        check("first_cap_data", {24'd0, cap_data}, 32'h0000_00A5);
        check("first_cap_slot", {30'd0, cap_slot}, 32'd2);
        check("d2_latency", d2_stb_cyc, t0 + L2);
        check("d2_oe_cycles", d2_oe_cnt, SETTLE2 + 1);

        // Round robin over all four slots.
        for (int s = 0; s < 4; s++) src_data[s] = 8'h10 + 8'(s);
        for (int s = 0; s < 4; s++) pulse(2'(s), 4'b1111, 3, 7, tk);
        repeat (10) @(negedge inclk);
        check("rr_last_data", {24'd0, cap_data}, 32'h0000_0013);

        // Ticks on an absent slot: counted, never granted, saturating.
        pulse(2'd1, 4'b1101, 2, 2, tk);
        repeat (4) @(negedge inclk);
        check("skip_one", {24'd0, skip_cnt}, 32'd1);
        for (int i = 0; i < 299; i++) pulse(2'd1, 4'b1101, 2, 2, tk);
        repeat (4) @(negedge inclk);
        check("skip_sat", {24'd0, skip_cnt}, 32'd255);

        // Second tick lands in DRIVE: ignored and counted.
        pulse(2'd0, 4'b1111, 1, 1, tk);
        pulse(2'd0, 4'b1111, 2, 3, tk);
        repeat (8) @(negedge inclk);
        check("ovr_one", {24'd0, ovr_cnt}, 32'd1);

        // Reset during DRIVE, scan_clk held high through release.
        src_data[3] = 8'h3C;
        pulse(2'd3, 4'b1111, 2, 3, tk);
        #2;
        check("pre_rst_oe", {28'd0, bus_oe}, 32'd8);
        chk_en   = 1'b0;
        scan_clk = 1'b1;
        rst      = 1'b1;
        #1;
        check("mid_rst_oe", {28'd0, bus_oe}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_skip", {24'd0, skip_cnt}, 32'd0);
        check("mid_rst_ovr", {24'd0, ovr_cnt}, 32'd0);
        check("mid_rst_data", {24'd0, cap_data}, 32'd0);
        acc_q.delete();
        cap_q.delete();
        m_last_t = -100;
        m_skip   = 0;
        m_ovr    = 0;
        repeat (3) @(negedge inclk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        repeat (10) @(negedge inclk);
        check("no_tick_high_release", {31'd0, busy}, 32'd0);
        #1 scan_clk = 1'b0;
        repeat (3) @(negedge inclk);
        pulse(2'd3, 4'b1111, 3, 4, tk);
        repeat (8) @(negedge inclk);
        check("post_rst_data", {24'd0, cap_data}, 32'h0000_003C);

        // Randomized ticks with random slot presence and spacing.
        for (int i = 0; i < 4; i++) src_data[i] = 8'($urandom);
        for (int i = 0; i < 150; i++) begin
            pulse(2'($urandom_range(0, 3)), 4'($urandom), $urandom_range(1, 4),
                  $urandom_range(2, 5), tk);
        end
        repeat (15) @(negedge inclk);
        check("final_skip", {24'd0, skip_cnt}, m_skip);
        check("final_ovr", {24'd0, ovr_cnt}, m_ovr);
        check("cap_q_drained", cap_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
